// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath: operand/accumulator widths,
// the dot-product sequencer state encoding and the vector length ceiling.
package mac_pkg;

  localparam int DATA_W        = 8;
  localparam int ACC_W         = 32;
  localparam int MAX_LEN_LIMIT = 256;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    FEED    = 3'd2,
    CAPTURE = 3'd3,
    RESULT  = 3'd4
  } dp_state_t;

endpackage

// File: rtl/dot_product_ctrl.sv
// Sequencer for mac_unit: clears the accumulator, feeds len operand pairs from a
// valid/ready stream, then holds the captured dot product on a valid/ready result port.
module dot_product_ctrl
  import mac_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_a,
  input  logic signed [DATA_W-1:0] in_b,
  output logic                     mac_enable,
  output logic                     mac_clear,
  output logic signed [DATA_W-1:0] mac_a,
  output logic signed [DATA_W-1:0] mac_b,
  input  logic signed [ACC_W-1:0]  mac_acc,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [ACC_W-1:0]  res_data,
  output logic                     busy,
  output dp_state_t                dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready depends only on state, so it never drops while a pair is waiting in FEED.
  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

  dp_state_t                state_q, state_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  res_q, res_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    in_ready   = 1'b0;
    mac_enable = 1'b0;
    mac_clear  = 1'b0;
    mac_a      = '0;
    mac_b      = '0;
    res_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = (len > MAX_LEN_V) ? MAX_LEN_V : len;
          cnt_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        mac_clear = 1'b1;
        state_d   = (len_q != '0) ? FEED : CAPTURE;
      end
      FEED: begin
        in_ready = 1'b1;
        mac_a    = in_a;
        mac_b    = in_b;
        if (in_valid) begin
          mac_enable = 1'b1;
          cnt_d      = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        // mac_acc already holds the final beat: it was enabled on the previous edge.
        res_d   = mac_acc;
        state_d = RESULT;
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign res_data  = res_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Directed bench for dot_product_ctrl with a behavioural mac_unit beside it;
// expected sums, beat counts and latencies are hand-computed per vector.
module tb_dot_product_ctrl;
  import mac_pkg::*;

  localparam int MAX_LEN = 64;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [LEN_W-1:0]         len;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_a, in_b;
  logic                     mac_enable, mac_clear;
  logic signed [DATA_W-1:0] mac_a, mac_b;
  logic signed [ACC_W-1:0]  mac_acc = '0;
  logic                     res_valid, res_ready;
  logic signed [ACC_W-1:0]  res_data;
  logic                     busy;
  dp_state_t                dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic signed [DATA_W-1:0] qa[$];
  logic signed [DATA_W-1:0] qb[$];

  dot_product_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_enable(mac_enable), .mac_clear(mac_clear), .mac_a(mac_a), .mac_b(mac_b),
    .mac_acc(mac_acc), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // mac_unit model: deliberately not reset, so only CLEAR removes stale sums
  always @(posedge clk) begin
    if (mac_clear) mac_acc <= '0;
    else if (mac_enable) mac_acc <= mac_acc + (mac_a * mac_b);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag,
               $signed(got), got, $signed(exp), exp);
    end
  endtask

  // Runs one job; pat gives in_valid per FEED cycle (bit 0 first, then held high).
  task automatic run_job(input int l, input logic [15:0] pat, input int pat_len,
                         input int hold, input bit start_in_feed, input bit start_in_hs,
                         input bit chain, input int exp_res, input int exp_en,
                         input int exp_lat, input string tag);
    int k, enables, feed_i, lat;
    bit done;
    if (!chain) @(negedge clk);
    start = 1'b1; len = LEN_W'(l); in_valid = 1'b0; res_ready = 1'b0;
    @(posedge clk);
    k = 1; enables = 0; feed_i = 0; lat = -1; done = 1'b0;
    while (!done && k < 2000) begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
      in_a = DATA_W'($urandom_range(1, 255));
      in_b = DATA_W'($urandom_range(1, 255));
      if (in_ready) begin
        in_valid = (feed_i < pat_len) ? pat[feed_i] : 1'b1;
        if (in_valid) begin
          in_a = (qa.size() > 0) ? qa[0] : 8'sd1;
          in_b = (qb.size() > 0) ? qb[0] : 8'sd1;
        end
        if (start_in_feed && feed_i == 1) start = 1'b1;
        feed_i++;
      end
      if (res_valid) begin
        if (lat < 0) lat = k;
        check({tag, " res_data"}, 32'(res_data), 32'(exp_res));
        if (hold > 0) hold--;
        else begin
          res_ready = 1'b1;
          if (start_in_hs) start = 1'b1;
          done = 1'b1;
        end
      end
      #1;
      check({tag, " clear_enable_overlap"}, 32'(mac_enable & mac_clear), 32'(0));
      check({tag, " mac_enable"}, 32'(mac_enable), 32'(in_valid & in_ready));
      check({tag, " mac_a"}, 32'(mac_a), in_ready ? 32'(in_a) : 32'(0));
      check({tag, " mac_b"}, 32'(mac_b), in_ready ? 32'(in_b) : 32'(0));
      if (in_valid && in_ready) begin
        enables++;
        if (qa.size() > 0) void'(qa.pop_front());
        if (qb.size() > 0) void'(qb.pop_front());
      end
      k++;
    end
    check({tag, " completed_before_timeout"}, 32'(done), 32'(1));
    check({tag, " enable_count"}, 32'(enables), 32'(exp_en));
    if (exp_lat >= 0) check({tag, " res_valid_latency"}, 32'(lat), 32'(exp_lat));
    @(negedge clk);
    start = 1'b0; res_ready = 1'b0; in_valid = 1'b0;
    #1;
    check({tag, " idle_after_handshake"}, 32'(busy), 32'(0));
    check({tag, " res_valid_dropped"}, 32'(res_valid), 32'(0));
    check({tag, " res_data_held"}, 32'(res_data), 32'(exp_res));
  endtask

  initial begin
    int accepted, guard;
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'(0));
    check("reset mac_enable", 32'(mac_enable), 32'(0));
    check("reset mac_clear", 32'(mac_clear), 32'(0));
    check("reset res_valid", 32'(res_valid), 32'(0));
    check("reset busy", 32'(busy), 32'(0));
    check("reset res_data", 32'(res_data), 32'(0));
    check("reset mac_a", 32'(mac_a), 32'(0));
    check("reset state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;

    // 1*5 + 2*6 + 3*7 + 4*8 = 70
    qa = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    qb = '{8'sd5, 8'sd6, 8'sd7, 8'sd8};
    run_job(4, 16'h0, 0, 0, 1'b0, 1'b0, 1'b0, 70, 4, 7, "basic");

    // 16384 - 16256 - 1 = 127
    qa = '{8'sh80, 8'sh7F, 8'shFF};
    qb = '{8'sh80, 8'sh80, 8'sh01};
    run_job(3, 16'h0, 0, 0, 1'b0, 1'b0, 1'b0, 127, 3, 6, "signed_extremes");

    // valid 1-0-0-1-1-0-1-1; 14 - 24 - 36 + 50 - 66 = -62
    qa = '{8'sd2, -8'sd3, 8'sd4, 8'sd5, -8'sd6};
    qb = '{8'sd7, 8'sd8, -8'sd9, 8'sd10, 8'sd11};
    run_job(5, 16'h00D9, 8, 3, 1'b0, 1'b0, 1'b0, -62, 5, -1, "bubbles_backpressure");

    qa.delete(); qb.delete();
    run_job(0, 16'h0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 3, "len_zero");

    // len saturates to 64; every pair is 1*1
    run_job(MAX_LEN + 5, 16'h0, 0, 0, 1'b0, 1'b0, 1'b0, MAX_LEN, MAX_LEN, MAX_LEN + 3,
            "len_oversize");

    // reset after 2 of 6 beats
    @(negedge clk);
    start = 1'b1; len = LEN_W'(6);
    @(posedge clk);
    #1;
    start = 1'b0;
    accepted = 0; guard = 0;
    while (accepted < 2 && guard < 50) begin
      @(negedge clk);
      in_valid = in_ready; in_a = 8'sd9; in_b = 8'sd9;
      #1;
      if (in_valid && in_ready) accepted++;
      guard++;
    end
    check("abort two_beats_fed", 32'(accepted), 32'(2));
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort state", 32'(dbg_state), 32'(IDLE));
    check("abort busy", 32'(busy), 32'(0));
    check("abort in_ready", 32'(in_ready), 32'(0));
    check("abort res_data", 32'(res_data), 32'(0));
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    qa = '{8'sd3, 8'sd3};
    qb = '{8'sd2, 8'sd2};
    run_job(2, 16'h0, 0, 0, 1'b0, 1'b0, 1'b0, 12, 2, 5, "after_abort");

    // start pulses in FEED and in the handshake cycle are ignored; 10+20+30 = 60
    qa = '{8'sd1, 8'sd1, 8'sd1};
    qb = '{8'sd10, 8'sd20, 8'sd30};
    run_job(3, 16'h0, 0, 0, 1'b1, 1'b1, 1'b0, 60, 3, 6, "ignored_start");
    // -30 - 28 = -58, started in the first IDLE cycle after the handshake
    qa = '{-8'sd5, 8'sd4};
    qb = '{8'sd6, -8'sd7};
    run_job(2, 16'h0, 0, 0, 1'b0, 1'b0, 1'b1, -58, 2, 5, "back_to_back");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dot_product_ctrl.md
# dot_product_ctrl

Sequencer that sits directly upstream of `mac_unit` and turns a streamed vector of signed 8-bit operand pairs into one dot-product result. On `start` it clears the accumulator, then accepts `len` operand pairs over a valid/ready stream. It forwards each pair to `mac_unit` with a one-cycle enable, then captures the 32-bit accumulator and presents it on a valid/ready result port. It owns all control of `mac_unit`; nothing else drives `mac_enable` or `mac_clear`.

## Interface
Parameters:
- `MAX_LEN`, default 64: maximum vector length, legal range 1..256.
- `LEN_W`, default $clog2(MAX_LEN+1): width of `len` and of the beat counter.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin a job; sampled only in IDLE.
- `len`  in  LEN_W  number of pairs; latched on an accepted `start`. Values above MAX_LEN saturate to MAX_LEN.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  controller accepts a pair this cycle.
- `in_a`, `in_b`  in  8 each  signed operands.
- `mac_enable`  out  1  drives `mac_unit.enable`.
- `mac_clear`  out  1  drives `mac_unit.clear_acc`.
- `mac_a`, `mac_b`  out  8 each  signed, drive `mac_unit.a`/`b`.
- `mac_acc`  in  32  signed, from `mac_unit.acc`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  downstream accepts the result.
- `res_data`  out  32  signed dot product, registered.
- `busy`  out  1  high in every state except IDLE.

## Operation
States: IDLE, CLEAR, FEED, CAPTURE, RESULT.
- IDLE: `in_ready`=0. On `start`=1, latch `len` into `len_q`, reset the beat counter `cnt` to 0, and go to CLEAR.
- CLEAR: held for exactly one cycle with `mac_clear`=1. Next state is FEED if `len_q`≠0, else CAPTURE.
- FEED: `in_ready`=1. A beat is accepted when `in_valid && in_ready`.
  - On an accepted beat: `mac_enable`=1 and `cnt` increments.
  - `mac_a`/`mac_b` are combinational pass-throughs of `in_a`/`in_b` while in FEED. They are 0 in all other states.
  - When the beat with `cnt`==`len_q`-1 is accepted, go to CAPTURE.
  - Cycles with `in_valid`=0 are idle bubbles: no enable, the counter holds, and there is no timeout.
- CAPTURE: one cycle. `res_data` <= `mac_acc`, which already includes the final beat. Go to RESULT.
- RESULT: `res_valid`=1 and `res_data` is held stable. On `res_ready`=1, go to IDLE and drop `res_valid` the next cycle.
- `start` is ignored outside IDLE, including in the cycle of the RESULT handshake.
- `mac_enable` and `mac_clear` are never high in the same cycle, and never high outside FEED and CLEAR respectively.
- Arithmetic is done entirely in `mac_unit`. The worst case is 256 × 16384 = 2^22, so no overflow is possible; no saturation logic exists.

## Timing
- Reset values: state IDLE; `in_ready`, `mac_enable`, `mac_clear`, `res_valid`, `busy` = 0; `mac_a`, `mac_b`, `res_data` = 0; `cnt`, `len_q` = 0.
- Reset mid-job aborts immediately to IDLE and discards the partial job. The next job's CLEAR state wipes the stale accumulator.
- Cycle T = `start` accepted:
  - T+1 is CLEAR.
  - T+2 is the first cycle in which a beat can be accepted.
- With `in_valid` held high:
  - beats are accepted on T+2 .. T+1+len;
  - CAPTURE is at T+2+len;
  - `res_valid` first rises at T+3+len.
- For `len`=0: CAPTURE is at T+2, `res_valid` rises at T+3, and `res_data`=0.
- Minimum start-to-start period is len+4 cycles when `res_ready` is held high.
- Stream rule: `in_a`/`in_b` must be stable while `in_valid`=1 and `in_ready`=0. The controller never drops `in_ready` within FEED.

## Structure
- Shared package `mac_pkg` holds:
  - `DATA_W`=8 and `ACC_W`=32;
  - the state enum `dp_state_t` {IDLE, CLEAR, FEED, CAPTURE, RESULT};
  - `MAX_LEN_LIMIT`=256.
  `mac_unit` and future array stages use the same package.
- No sub-module inside this block: the FSM and beat counter are a single module.
- `mac_unit` is instantiated beside this block in the parent `dot_product_engine`, which wires the `mac_*` ports together.

## Test plan
- Basic dot product: `len`=4, a={1,2,3,4}, b={5,6,7,8}, `in_valid` held high, `res_ready` high.
  - Expect 4 `mac_enable` pulses, then `res_data`=70.
  - Expect `res_valid` exactly 7 cycles after the `start` edge.
- Signed extremes: `len`=3, pairs (-128,-128), (127,-128), (-1,1).
  - Expect `res_data`=16384-16256-1=127.
- Bubbles and backpressure: `len`=5, with `in_valid` toggled 1-0-0-1-1-0-1-1 and `res_ready` held low for 3 cycles.
  - Expect the correct sum and exactly 5 enables.
  - Expect `res_data` stable and `res_valid` high until the handshake.
- Zero and oversize length:
  - `len`=0: result 0, no `mac_enable`, `res_valid` 3 cycles after `start`.
  - `len`=MAX_LEN+5: exactly MAX_LEN beats are accepted.
- Reset mid-FEED: assert `rst` after 2 of 6 beats, then run a new job with `len`=2, a={3,3}, b={2,2}.
  - Expect `res_data`=12, with no stale contribution.
- Ignored start and back-to-back jobs: pulse `start` during FEED and in the RESULT handshake cycle.
  - Expect no effect.
  - A `start` in the following IDLE cycle runs a second job correctly.
